fetch_unit: RTL and testbench

Instruction-fetch stage. It consumes pc_select and clear_pipes from the branch/PC controller and owns the program counter. It issues one-outstanding-request reads to instruction memory and loads the IF/ID pipeline register that feeds decode. It handles stalls from the hazard unit, and redirects/flushes from the branch controller, including killing an in-flight fetch.

---
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem reads, loads IF/ID.
// Optional FETCH_MISALIGN_CHECK_EN aligns redirect targets and raises a sticky misalign flag.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_INC   = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              pc_select_i,
  input  logic              clear_pipes_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              stall_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_valid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic [ADDR_W-1:0] pc_if_id_o,
  output logic [DATA_W-1:0] instr_if_id_o,
  output logic              valid_if_id_o,
  output logic              misalign_o
);

  typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, DROP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] hold_pc_q;
  logic [DATA_W-1:0] hold_instr_q;
  logic              load, capture;
  logic [ADDR_W-1:0] ld_pc;
  logic [DATA_W-1:0] ld_instr;
  logic [ADDR_W-1:0] target;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;
  assign target     = {branch_target_i[ADDR_W-1:2], 2'b00};
  assign misalign_o = misalign_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      misalign_q <= 1'b0;
    end else if (pc_select_i && (branch_target_i[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end
  end
`else
  assign target     = branch_target_i;
  assign misalign_o = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    load     = 1'b0;
    capture  = 1'b0;
    ld_pc    = pc_q;
    ld_instr = imem_rdata_i;
    case (state_q)
      BOOT: state_d = REQ;
      REQ:  state_d = WAIT;
      WAIT: begin
        if (imem_valid_i) begin
          if (stall_i) begin
            capture = 1'b1;
            state_d = HOLD;
          end else begin
            load    = 1'b1;
            pc_d    = pc_q + ADDR_W'(PC_INC);
            state_d = REQ;
          end
        end
      end
      HOLD: begin
        if (!stall_i) begin
          load     = 1'b1;
          ld_pc    = hold_pc_q;
          ld_instr = hold_instr_q;
          pc_d     = pc_q + ADDR_W'(PC_INC);
          state_d  = REQ;
        end
      end
      DROP: if (imem_valid_i) state_d = REQ;
      default: state_d = BOOT;
    endcase
    // A redirect kills any pending delivery; wait out a response only if one is still in flight.
    if (pc_select_i) begin
      pc_d    = target;
      load    = 1'b0;
      capture = 1'b0;
      if ((state_q == REQ) ||
          (((state_q == WAIT) || (state_q == DROP)) && !imem_valid_i))
        state_d = DROP;
      else
        state_d = REQ;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      imem_req_o    <= 1'b0;
      imem_addr_o   <= RESET_PC;
      hold_pc_q     <= '0;
      hold_instr_q  <= '0;
      pc_if_id_o    <= '0;
      instr_if_id_o <= '0;
      valid_if_id_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imem_req_o  <= (state_d == REQ);
      imem_addr_o <= pc_d;
      if (capture) begin
        hold_pc_q    <= pc_q;
        hold_instr_q <= imem_rdata_i;
      end
      // IF/ID register: flush beats stall, stall beats load.
      if (clear_pipes_i) begin
        valid_if_id_o <= 1'b0;
      end else if (!stall_i) begin
        valid_if_id_o <= load;
        if (load) begin
          pc_if_id_o    <= ld_pc;
          instr_if_id_o <= ld_instr;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency instruction memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_select = 1'b0;
  logic        clear_pipes = 1'b0;
  logic [31:0] branch_target = '0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc_if_id;
  logic [31:0] instr_if_id;
  logic        valid_if_id;
  logic        misalign;

  int checks = 0;
  int failures = 0;
  int lat = 1;
  int cnt = 0;
  logic pend = 1'b0;
  logic [31:0] paddr = '0;

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic MIS_EN = 1'b1;
`else
  localparam logic MIS_EN = 1'b0;
`endif

  fetch_unit dut (
    .clk_i(clk), .rst_n_i(rst_n), .pc_select_i(pc_select), .clear_pipes_i(clear_pipes),
    .branch_target_i(branch_target), .stall_i(stall), .imem_req_o(imem_req),
    .imem_addr_o(imem_addr), .imem_valid_i(imem_valid), .imem_rdata_i(imem_rdata),
    .pc_if_id_o(pc_if_id), .instr_if_id_o(instr_if_id), .valid_if_id_o(valid_if_id),
    .misalign_o(misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h8) ? 32'hDEAD_BEEF : (a ^ 32'h1234_5678);
  endfunction

  // Memory: response appears 'lat' cycles after the request cycle, one cycle wide.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
      imem_valid = 1'b0;
    end else begin
      imem_valid = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = mem_word(paddr);
          pend = 1'b0;
        end else begin
          cnt = cnt - 1;
        end
      end
      if (imem_req) begin
        pend = 1'b1;
        cnt = lat - 1;
        paddr = imem_addr;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] mexp;
    mexp = MIS_EN ? 32'h100 : 32'h103;

    // Reset state
    tick();
    tick();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", valid_if_id, 0);
    chk("rst_pc", pc_if_id, 0);
    chk("rst_instr", instr_if_id, 0);
    chk("rst_mis", misalign, 0);
    rst_n = 1'b1;

    // Sequential fetch, 1-cycle memory
    tick();
    chk("boot_req", imem_req, 1);
    chk("boot_addr", imem_addr, 32'h0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("seq_bubble", valid_if_id, 0);
      chk("seq_req_lo", imem_req, 0);
      tick();
      chk("seq_valid", valid_if_id, 1);
      chk("seq_pc", pc_if_id, 32'(4 * k));
      chk("seq_instr", instr_if_id, mem_word(32'(4 * k)));
      chk("seq_req", imem_req, 1);
      chk("seq_addr", imem_addr, 32'(4 * (k + 1)));
    end

    // Response for 0x8 lands during a 3-cycle stall
    tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_valid", valid_if_id, 0);
      chk("stall_pc", pc_if_id, 32'h4);
      chk("stall_instr", instr_if_id, mem_word(32'h4));
      chk("stall_req", imem_req, 0);
    end
    stall = 1'b0;
    lat = 3;
    tick();
    chk("hold_valid", valid_if_id, 1);
    chk("hold_pc", pc_if_id, 32'h8);
    chk("hold_instr", instr_if_id, 32'hDEAD_BEEF);
    chk("hold_next_req", imem_req, 1);
    chk("hold_next_addr", imem_addr, 32'hC);

    // Redirect + flush during WAIT with 3-cycle latency
    tick();
    pc_select = 1'b1;
    clear_pipes = 1'b1;
    branch_target = 32'h100;
    tick();
    pc_select = 1'b0;
    clear_pipes = 1'b0;
    chk("flush_valid", valid_if_id, 0);
    chk("drop_req0", imem_req, 0);
    tick();
    chk("drop_req1", imem_req, 0);
    chk("drop_valid", valid_if_id, 0);
    tick();
    chk("redir_req", imem_req, 1);
    chk("redir_addr", imem_addr, 32'h100);
    tick();
    tick();
    tick();
    tick();
    chk("redir_valid", valid_if_id, 1);
    chk("redir_pc", pc_if_id, 32'h100);
    chk("redir_instr", instr_if_id, mem_word(32'h100));
    chk("redir_next_addr", imem_addr, 32'h104);

    // Redirect to 0x40 together with response and stall
    tick();
    tick();
    tick();
    pc_select = 1'b1;
    branch_target = 32'h40;
    stall = 1'b1;
    lat = 1;
    tick();
    pc_select = 1'b0;
    chk("vr_req", imem_req, 1);
    chk("vr_addr", imem_addr, 32'h40);
    chk("vr_valid", valid_if_id, 0);
    chk("vr_pc", pc_if_id, 32'h100);
    tick();
    chk("vr_req_lo", imem_req, 0);
    tick();
    chk("vr_stall_valid", valid_if_id, 0);
    chk("vr_stall_pc", pc_if_id, 32'h100);
    stall = 1'b0;
    tick();
    chk("vr_load_valid", valid_if_id, 1);
    chk("vr_load_pc", pc_if_id, 32'h40);
    chk("vr_load_instr", instr_if_id, mem_word(32'h40));
    chk("vr_next_addr", imem_addr, 32'h44);

    // Redirect during REQ to top of address space, then wrap
    pc_select = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    tick();
    pc_select = 1'b0;
    chk("reqdrop_req", imem_req, 0);
    chk("reqdrop_valid", valid_if_id, 0);
    tick();
    chk("top_req", imem_req, 1);
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    chk("top_valid", valid_if_id, 1);
    chk("top_pc", pc_if_id, 32'hFFFF_FFFC);
    chk("wrap_req", imem_req, 1);
    chk("wrap_addr", imem_addr, 32'h0);

    // Misaligned redirect, then flush overriding a load
    tick();
    pc_select = 1'b1;
    branch_target = 32'h103;
    tick();
    pc_select = 1'b0;
    chk("mis_req", imem_req, 1);
    chk("mis_addr", imem_addr, mexp);
    chk("mis_flag", misalign, 32'(MIS_EN));
    tick();
    clear_pipes = 1'b1;
    tick();
    clear_pipes = 1'b0;
    chk("clr_valid", valid_if_id, 0);
    chk("clr_next_addr", imem_addr, mexp + 32'h4);
    tick();
    tick();
    chk("mis_sticky", misalign, 32'(MIS_EN));

    // Asynchronous reset mid-operation
    rst_n = 1'b0;
    #1;
    chk("arst_req", imem_req, 0);
    chk("arst_addr", imem_addr, 0);
    chk("arst_valid", valid_if_id, 0);
    chk("arst_pc", pc_if_id, 0);
    chk("arst_mis", misalign, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
